// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, prefix codes and helpers for the PS/2 key decoder
package ps2_pkg;

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard replies to host commands; these never represent a key.
  localparam logic [7:0] PS2_RESP_CODES [8] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
  };

  // Parity bit that makes the byte plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

  function automatic logic is_response(input logic [7:0] value);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (value == PS2_RESP_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchronises the raw PS/2 lines, deglitches the clock and
// produces a one-cycle strobe on each filtered clock fall
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic fall,
  output logic data
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      fall      <= 1'b0;
      // Any sample agreeing with the filtered level restarts the run of differing samples.
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data = data_sync[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver producing the 11-bit ps2_key
// event word {toggle, pressed, extended, code}
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          fall;
  logic          data;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;
  logic [TW-1:0] tmo;
  logic          ext;
  logic          brk;
  ps2_key_t      key;
  logic [7:0]    code;
  logic          parity_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .fall        (fall),
    .data        (data)
  );

  // After nine shifts the data byte sits in [7:0] and the parity bit in [8].
  assign code      = shift[7:0];
  assign parity_ok = (shift[8] == odd_parity(code));
  assign ps2_key   = key;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift     <= '0;
      tmo       <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      key       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall) begin
        tmo <= '0;
        if (bit_cnt == 4'd0) begin
          // A high start bit is line noise, not a frame; stay idle.
          if (!data) bit_cnt <= 4'd1;
        end else if (bit_cnt != 4'd10) begin
          shift   <= {data, shift[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          bit_cnt <= 4'd0;
          if (!data || !parity_ok) begin
            frame_err <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
          end else if (code == PS2_EXT) begin
            ext <= 1'b1;
          end else if (code == PS2_BRK) begin
            brk <= 1'b1;
          end else if (code != PS2_PAUSE) begin
            // E1 is swallowed so Pause arrives as ordinary 14/77 make and break events.
            if (!is_response(code)) begin
              key <= {~key.toggle, ~brk, ext, code};
            end
            ext <= 1'b0;
            brk <= 1'b0;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (tmo == TMO_LAST) begin
          bit_cnt   <= 4'd0;
          tmo       <= '0;
          frame_err <= 1'b1;
          ext       <= 1'b0;
          brk       <= 1'b0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int F    = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] key;
  logic        ferr;

  int total = 0;
  int passed = 0;
  int ferr_cnt = 0;
  int ev_cnt = 0;
  logic [10:0] last_key = '0;

  ps2_key_decoder #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys     (clk),
    .reset       (rst),
    .ps2_clk_in  (ps2_clk),
    .ps2_data_in (ps2_data),
    .ps2_key     (key),
    .frame_err   (ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr === 1'b1) ferr_cnt++;
    if (key !== last_key) ev_cnt++;
    last_key = key;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(15);
      ps2_clk = 1'b0;
      wait_cycles(F - 1);
      ps2_clk = 1'b1;
      wait_cycles(HALF - 15 - (F - 1));
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] code, input bit bad_par);
    return {1'b1, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic send_partial(input logic [7:0] code, input int nbits);
    logic [10:0] bits;
    bits = frame_bits(code, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(bits[i], 1'b0);
  endtask

  // pre/post are ps2_key one cycle before and exactly at F+3 cycles after the stop fall.
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input int glitch_bit,
                            output logic [10:0] pre, output logic [10:0] post);
    logic [10:0] bits;
    bits = frame_bits(code, bad_par);
    for (int i = 0; i < 10; i++) send_bit(bits[i], i == glitch_bit);
    ps2_data = bits[10];
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    repeat (F + 2) @(posedge clk);
    #1 pre = key;
    @(posedge clk);
    #1 post = key;
    wait_cycles(HALF - F - 3);
    ps2_clk = 1'b1;
    wait_cycles(2 * HALF);
  endtask

  initial begin
    logic [10:0] pre, post;
    int f0, e0;

    wait_cycles(3);
    check("reset_key", 32'(key), 32'h0);
    check("reset_err", 32'(ferr), 32'h0);
    rst = 1'b0;
    wait_cycles(5);

    // 1: single make code with exact latency
    send_frame(8'h1C, 1'b0, -1, pre, post);
    check("t1_before_latency", 32'(pre), 32'h0);
    check("t1_at_latency", 32'(post), 32'h61C);

    // 2: extended make then extended break
    do_reset();
    e0 = ev_cnt;
    send_frame(8'hE0, 1'b0, -1, pre, post);
    check("t2_e0_no_event", 32'(post), 32'h0);
    send_frame(8'h75, 1'b0, -1, pre, post);
    check("t2_ext_make", 32'(post), 32'h775);
    send_frame(8'hE0, 1'b0, -1, pre, post);
    send_frame(8'hF0, 1'b0, -1, pre, post);
    check("t2_prefix_hold", 32'(post), 32'h775);
    send_frame(8'h75, 1'b0, -1, pre, post);
    check("t2_ext_break", 32'(post), 32'h175);
    check("t2_event_count", 32'(ev_cnt - e0), 32'd2);

    // 3: parity error then clean frame
    do_reset();
    f0 = ferr_cnt;
    send_frame(8'h29, 1'b1, -1, pre, post);
    check("t3_bad_par_key", 32'(post), 32'h0);
    check("t3_bad_par_err", 32'(ferr_cnt - f0), 32'd1);
    send_frame(8'h29, 1'b0, -1, pre, post);
    check("t3_good_key", 32'(post), 32'h629);
    check("t3_good_no_err", 32'(ferr_cnt - f0), 32'd1);

    // 4: truncated frame then timeout
    do_reset();
    f0 = ferr_cnt;
    send_partial(8'h16, 5);
    wait_cycles(TMO + 100);
    check("t4_timeout_err", 32'(ferr_cnt - f0), 32'd1);
    check("t4_timeout_key", 32'(key), 32'h0);
    send_frame(8'h16, 1'b0, -1, pre, post);
    check("t4_after_timeout", 32'(post), 32'h616);

    // 5: clock glitch one sample short of the filter length, device responses
    do_reset();
    f0 = ferr_cnt;
    e0 = ev_cnt;
    send_frame(8'hFA, 1'b0, 4, pre, post);
    send_frame(8'hAA, 1'b0, -1, pre, post);
    check("t5_resp_key", 32'(post), 32'h0);
    check("t5_glitch_no_err", 32'(ferr_cnt - f0), 32'd0);
    check("t5_no_event", 32'(ev_cnt - e0), 32'd0);
    send_frame(8'h1C, 1'b0, 2, pre, post);
    check("t5_glitch_frame", 32'(post), 32'h61C);

    // 6: reset in mid-frame
    do_reset();
    send_frame(8'h1C, 1'b0, -1, pre, post);
    check("t6_first_key", 32'(post), 32'h61C);
    send_partial(8'h29, 6);
    @(negedge clk);
    rst = 1'b1;
    #1 check("t6_async_reset", 32'(key), 32'h0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(5);
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, -1, pre, post);
    check("t6_after_reset", 32'(post), 32'h61C);
    check("t6_no_err", 32'(ferr_cnt - f0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
